// File: rtl/toggle_pulse_gen_if.sv
// Button-side signal bundle for toggle_pulse_gen: raw button and enable in,
// toggle pulse, debounced level and press count out.
interface toggle_pulse_gen_if #(
    parameter int CNT_W = 8
);
    logic             btn;
    logic             en;
    logic             t;
    logic             btn_db;
    logic [CNT_W-1:0] press_cnt;

    modport master (
        output btn,
        output en,
        input  t,
        input  btn_db,
        input  press_cnt
    );

    modport slave (
        input  btn,
        input  en,
        output t,
        output btn_db,
        output press_cnt
    );
endinterface

// File: rtl/toggle_pulse_gen.sv
// Debounces a raw push-button and emits one registered t pulse per accepted
// press, for driving a T flip-flop; also exports debounced level and press count.
module toggle_pulse_gen #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    toggle_pulse_gen_if.slave bus
);
    localparam int            CW       = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             t_reg, t_next;
    logic             btn_db_reg, btn_db_next;
    logic [CNT_W-1:0] press_cnt_reg, press_cnt_next;
    logic             btn_m_reg, btn_s_reg;

    // Two-flop synchronizer; only btn_s_reg is seen by the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_m_reg <= 1'b0;
            btn_s_reg <= 1'b0;
        end else begin
            btn_m_reg <= bus.btn;
            btn_s_reg <= btn_m_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            t_reg         <= 1'b0;
            btn_db_reg    <= 1'b0;
            press_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            t_reg         <= t_next;
            btn_db_reg    <= btn_db_next;
            press_cnt_reg <= press_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        t_next         = 1'b0;
        btn_db_next    = btn_db_reg;
        press_cnt_next = press_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (btn_s_reg) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next  = HELD;
                    cnt_next    = '0;
                    btn_db_next = 1'b1;
                    // en only matters on this edge; a later rise never pulses.
                    if (bus.en) begin
                        t_next         = 1'b1;
                        press_cnt_next = press_cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s_reg) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = CW'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s_reg) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next  = IDLE;
                    cnt_next    = '0;
                    btn_db_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign bus.t         = t_reg;
    assign bus.btn_db    = btn_db_reg;
    assign bus.press_cnt = press_cnt_reg;
endmodule

// File: doc/toggle_pulse_gen.md
Name: toggle_pulse_gen

Overview:
- Upstream stage for the SR-based T flip-flop. Converts a raw, bouncing push-button level into a clean one-cycle `t` pulse, one pulse per debounced press.
- Its `t` output drives the T flip-flop's `t` input directly. The flip-flop therefore toggles exactly once per physical press.
- Also exports the debounced level and a running press count for observation.

Parameters:
- DB_CYCLES, 4, consecutive synchronized samples at the new level required to accept a press or release. Legal range is 2 to 255.
- CNT_W, 8, width of press_cnt.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. 0 clears all state immediately, independent of clk.
- btn  input  1  raw button level, asynchronous to clk, may bounce.
- en  input  1  pulse enable; when 0, debouncing continues but no t pulse and no count.
- t  output  1  one-clock-wide toggle pulse to the T flip-flop.
- btn_db  output  1  debounced button level.
- press_cnt  output  CNT_W  number of accepted, enabled presses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0): both synchronizer flops, the debounce counter, state, t, btn_db and press_cnt all go to 0 asynchronously. State goes to IDLE. Deassertion takes effect at the next rising edge.
- Synchronizer: btn passes through two flops (btn_m, then btn_s). The FSM uses only btn_s.
- Debounce counter: width ceil(log2(DB_CYCLES))+1. It is cleared on every state entry not listed below.
- IDLE (btn_db=0):
  - btn_s=1 -> PRESS_WAIT, cnt=1.
- PRESS_WAIT:
  - btn_s=0 -> IDLE, cnt=0 (glitch rejected).
  - btn_s=1 and cnt==DB_CYCLES-1 -> HELD. btn_db<=1. If en=1: t<=1 and press_cnt<=press_cnt+1.
  - Otherwise cnt++.
- HELD (btn_db=1):
  - btn_s=0 -> RELEASE_WAIT, cnt=1.
- RELEASE_WAIT:
  - btn_s=1 -> HELD, cnt=0, with no new pulse.
  - btn_s=0 and cnt==DB_CYCLES-1 -> IDLE, btn_db<=0.
  - Otherwise cnt++.
- t rules:
  - t is registered and high for exactly one cycle; it is cleared on the following edge in all cases.
  - A press held indefinitely yields exactly one pulse.
  - Releases never produce a pulse.
- en rules:
  - en is sampled only on the HELD-entry edge.
  - A press accepted with en=0 is not retroactively pulsed when en later rises.
- Latency: let edge E0 be the first rising edge at which btn=1 is sampled by btn_m, with btn stable thereafter.
  - t and btn_db rise after edge E(DB_CYCLES+1). For DB_CYCLES=4 this is E5.
  - t falls after E(DB_CYCLES+2).
  - Release latency to btn_db=0 is symmetric: btn_db falls after E(DB_CYCLES+1), counted from the first edge sampling btn=0.
- Wrap: press_cnt at 2^CNT_W-1 plus an accepted press gives 0, and t still pulses.
- Reset mid-operation, in any state: outputs go to 0 at once. After release, a press still held restarts from IDLE and yields a fresh pulse after the full latency.
- No combinational path from btn or en to any output.

Test Plan:
- Reset check: reset=0 with btn=1 and clk running -> t=0, btn_db=0, press_cnt=0 throughout. Release reset with btn=0 -> outputs stay 0.
- Clean press, DB_CYCLES=4, en=1: btn 0->1 sampled at E0 and held for 50 cycles -> t=1 only between E5 and E6, btn_db=1 from E5, press_cnt=1, no further t.
- Glitch and bounce rejection:
  - btn high for 2 cycles, then low -> no t, btn_db stays 0.
  - On release, btn bounces 1-0-1-0 with 1-cycle spacing, then stays 0 -> btn_db falls only DB_CYCLES+1 edges after the final 0 is first sampled, with zero t pulses.
- Enable gating: press with en=0 -> btn_db=1, t stays 0, press_cnt unchanged. Raise en while still held -> still no t. Next press with en=1 -> one pulse and press_cnt+1.
- Wrap: preload press_cnt to 255 by 255 presses (CNT_W=8). Next press -> press_cnt=0 and t pulses once.
- Reset mid-press: assert reset=0 in PRESS_WAIT (cnt=2) and again in HELD -> immediate 0 outputs. Release reset with btn held -> one pulse DB_CYCLES+1 edges after the first post-reset sampling edge.
